status_flag_unit: RTL
=====================

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 Parameter W, 4, operand/result width in bits (W >= 2).
REQ-002 Parameter OPW, 4, opcode width in bits.
REQ-003 Parameter CNT_W, 8, overflow event counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operation result presented this cycle.
REQ-007 opcode  input  OPW  operation code, values from shared alu_ops package.
REQ-008 op_a, op_b  input  W each  ALU operands of the presented operation.
REQ-009 op_result  input  W  ALU result of the presented operation.
REQ-010 add_cout, sub_cout  input  1 each  carry-out of adder / subtractor.
REQ-011 sticky_clr  input  1  clear sticky flags and event counter.
REQ-012 out_valid  output  1  flags below updated from an accepted operation last cycle.
REQ-013 negative, zero, cout, overflow  output  1 each  registered status flags.
REQ-014 sticky_v, sticky_c  output  1 each  accumulated overflow / carry since last clear.
REQ-015 ovf_count  output  CNT_W  saturating count of overflow events.

Function
REQ-016 An operation SHALL be accepted on every rising edge with in_valid=1; no backpressure exists.
REQ-017 Flags SHALL be registered: latency from accepted in_valid to flag outputs and out_valid is exactly 1 cycle.
REQ-018 out_valid SHALL equal in_valid of the previous cycle (single-cycle pulse per op).
REQ-019 With in_valid=0, negative/zero/cout/overflow SHALL hold their previous values.
REQ-020 zero SHALL be 1 iff op_result is all-zero; negative SHALL equal op_result[W-1], for every opcode.
REQ-021 ADD_OP: cout=add_cout; overflow=1 iff op_a[W-1]==op_b[W-1] and op_result[W-1]!=op_a[W-1].
REQ-022 SUB_OP: cout=sub_cout; overflow=1 iff op_a[W-1]!=op_b[W-1] and op_result[W-1]!=op_a[W-1].
REQ-023 Any other opcode: cout=0, overflow=0; no case falls through to ADD/SUB behaviour.
REQ-024 sticky_v SHALL set on an accepted op with computed overflow=1; sticky_c likewise on cout=1; both hold until sticky_clr or rst.
REQ-025 ovf_count SHALL increment by 1 per accepted overflow and saturate at 2^CNT_W-1 (no wrap).
REQ-026 sticky_clr with no concurrent accepted event SHALL zero sticky_v, sticky_c, ovf_count next cycle; flag outputs unaffected.
REQ-027 sticky_clr concurrent with an accepted overflow/carry: the new event SHALL win: sticky bit=1, ovf_count=1 (carry-only: sticky_c=1, ovf_count=0).

Reset
REQ-028 rst=1 SHALL on the next edge zero every output: out_valid, all flags, sticky bits, ovf_count.
REQ-029 rst SHALL take priority over in_valid and sticky_clr in the same cycle; the concurrent op is discarded.
REQ-030 First op accepted after rst deasserts SHALL behave as from cold reset, no residual state.

Structure
REQ-031 Opcode values (ADD_OP, SUB_OP, others) and a packed flag struct {n,z,c,v} SHALL live in package alu_ops.
REQ-032 Combinational flag evaluation (REQ-020..023) SHALL be one sub-module, flag_eval; status_flag_unit holds registers, sticky logic and counter.

Verification (W=4)
REQ-033 ADD a=0111 b=0001 r=1000 add_cout=0 -> next cycle out_valid=1 N=1 Z=0 C=0 V=1 sticky_v=1 ovf_count=1.
REQ-034 SUB a=1000 b=0001 r=0111 sub_cout=1 -> N=0 Z=0 C=1 V=1 sticky_c=1.
REQ-035 ADD a=1111 b=0001 r=0000 add_cout=1, then non-ADD/SUB opcode r=0000 -> first Z=1 C=1 V=0; second Z=1 C=0 V=0.
REQ-036 CNT_W=2, five consecutive overflowing ADDs -> ovf_count 1,2,3,3,3; then sticky_clr with sixth overflow -> ovf_count=1 sticky_v=1.
REQ-037 rst asserted same cycle as overflowing in_valid after prior activity -> next cycle all outputs 0, out_valid=0.
REQ-038 in_valid idle 3 cycles after an op -> flags hold, out_valid=0 throughout.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared ALU opcode encodings and the packed status-flag record used by the
// flag evaluator and the status register block.
package alu_ops;

  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    ADD_OP  = 4'h0,
    SUB_OP  = 4'h1,
    AND_OP  = 4'h2,
    OR_OP   = 4'h3,
    XOR_OP  = 4'h4,
    PASS_OP = 4'h5
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/status_flag_unit_if.sv
// Operation/status bundle between an ALU front end (master) and the status
// flag unit (slave).
interface status_flag_unit_if #(
  parameter int W     = 4,
  parameter int OPW   = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [OPW-1:0]   opcode;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     op_result;
  logic             add_cout;
  logic             sub_cout;
  logic             sticky_clr;
  logic             out_valid;
  logic             negative;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             sticky_v;
  logic             sticky_c;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, opcode, op_a, op_b, op_result, add_cout, sub_cout, sticky_clr,
    input  out_valid, negative, zero, cout, overflow, sticky_v, sticky_c, ovf_count
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, op_result, add_cout, sub_cout, sticky_clr,
    output out_valid, negative, zero, cout, overflow, sticky_v, sticky_c, ovf_count
  );

endinterface

// File: rtl/status_flag_unit_flag_eval.sv
// Purely combinational N/Z/C/V evaluation for one presented ALU operation.
module flag_eval
  import alu_ops::*;
#(
  parameter int W   = 4,
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  input  logic [W-1:0]   i_opA,
  input  logic [W-1:0]   i_opB,
  input  logic [W-1:0]   i_opResult,
  input  logic           i_addCout,
  input  logic           i_subCout,
  output flags_t         o_flags
);

  // N and Z come from the result for every opcode; C and V only mean
  // something for add and subtract, everything else reports them clear.
  always_comb begin
    o_flags   = '0;
    o_flags.n = i_opResult[W-1];
    o_flags.z = (i_opResult == '0);
    case (i_opcode)
      OPW'(ADD_OP): begin
        o_flags.c = i_addCout;
        o_flags.v = (i_opA[W-1] == i_opB[W-1]) && (i_opResult[W-1] != i_opA[W-1]);
      end
      OPW'(SUB_OP): begin
        o_flags.c = i_subCout;
        o_flags.v = (i_opA[W-1] != i_opB[W-1]) && (i_opResult[W-1] != i_opA[W-1]);
      end
      default: begin
        o_flags.c = 1'b0;
        o_flags.v = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// Status flag unit: registers the evaluated flags one cycle after each
// accepted operation and accumulates sticky overflow/carry plus a saturating
// overflow event counter.
module status_flag_unit
  import alu_ops::*;
#(
  parameter int W     = 4,
  parameter int OPW   = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  status_flag_unit_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  flags_t           w_flags;
  logic             w_ovfEvent;
  logic             w_carryEvent;

  logic             r_outValid;
  flags_t           r_flags;
  logic             r_stickyV;
  logic             r_stickyC;
  logic [CNT_W-1:0] r_ovfCount;

  flag_eval #(
    .W   (W),
    .OPW (OPW)
  ) u_flagEval (
    .i_opcode   (bus.opcode),
    .i_opA      (bus.op_a),
    .i_opB      (bus.op_b),
    .i_opResult (bus.op_result),
    .i_addCout  (bus.add_cout),
    .i_subCout  (bus.sub_cout),
    .o_flags    (w_flags)
  );

  assign w_ovfEvent   = bus.in_valid && w_flags.v;
  assign w_carryEvent = bus.in_valid && w_flags.c;

  // Capture flags on accepted ops and hold them otherwise; out_valid is the
  // one-cycle-delayed copy of in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_flags    <= '0;
    end else begin
      r_outValid <= bus.in_valid;
      if (bus.in_valid) begin
        r_flags <= w_flags;
      end
    end
  end

  // Sticky bits: a new event in the same cycle as a clear wins, so the set
  // term is tested before the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stickyV <= 1'b0;
      r_stickyC <= 1'b0;
    end else begin
      if (w_ovfEvent) begin
        r_stickyV <= 1'b1;
      end else if (bus.sticky_clr) begin
        r_stickyV <= 1'b0;
      end
      if (w_carryEvent) begin
        r_stickyC <= 1'b1;
      end else if (bus.sticky_clr) begin
        r_stickyC <= 1'b0;
      end
    end
  end

  // Overflow counter saturates at all-ones; a clear restarts it, counting
  // the concurrent overflow if there is one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfCount <= '0;
    end else if (bus.sticky_clr) begin
      r_ovfCount <= w_ovfEvent ? CNT_W'(1) : '0;
    end else if (w_ovfEvent && (r_ovfCount != CNT_MAX)) begin
      r_ovfCount <= r_ovfCount + CNT_W'(1);
    end
  end

  assign bus.out_valid = r_outValid;
  assign bus.negative  = r_flags.n;
  assign bus.zero      = r_flags.z;
  assign bus.cout      = r_flags.c;
  assign bus.overflow  = r_flags.v;
  assign bus.sticky_v  = r_stickyV;
  assign bus.sticky_c  = r_stickyC;
  assign bus.ovf_count = r_ovfCount;

endmodule
